// File: rtl/pss_generator_if.sv
// Bundles the start-request and sample-stream handshakes of the PSS generator.
// Ports: s_axis_in_* (2-bit N_id_2 request), m_axis_out_* ({im,re} samples + tlast), err_o.
// master = generator side, slave = requester/consumer side.
interface pss_generator_if #(
  parameter int OUT_DW = 32
);
  logic [1:0]        s_axis_in_tdata;
  logic              s_axis_in_tvalid;
  logic              s_axis_in_tready;
  logic [OUT_DW-1:0] m_axis_out_tdata;
  logic              m_axis_out_tvalid;
  logic              m_axis_out_tready;
  logic              m_axis_out_tlast;
  logic              err_o;

  modport master (
    input  s_axis_in_tdata, s_axis_in_tvalid, m_axis_out_tready,
    output s_axis_in_tready, m_axis_out_tdata, m_axis_out_tvalid, m_axis_out_tlast, err_o
  );

  modport slave (
    output s_axis_in_tdata, s_axis_in_tvalid, m_axis_out_tready,
    input  s_axis_in_tready, m_axis_out_tdata, m_axis_out_tvalid, m_axis_out_tlast, err_o
  );
endinterface

// File: rtl/pss_generator.sv
// Purpose: streams the 127-sample NR PSS for a requested N_id_2 as BPSK {im=0, re=+/-AMPLITUDE}.
// Latency: start handshake to first valid sample = 1 + 43*N_id_2 cycles, then one sample per beat.
// Backpressure: output holds data/last/LFSR while tready is low; new requests refused until the sequence ends.
// Ports: clk_i, reset_ni (synchronous, active-low), bus (pss_generator_if.master):
//   s_axis_in_* request N_id_2 (3 is rejected with a one-cycle err_o pulse),
//   m_axis_out_* sample stream with tlast on n=126.
module pss_generator #(
  parameter int OUT_DW    = 32,
  parameter int AMPLITUDE = 2**(OUT_DW/2-1)-1,
  parameter int PSS_LEN   = 127
) (
  input logic               clk_i,
  input logic               reset_ni,
  pss_generator_if.master   bus
);

  localparam int HW = OUT_DW/2;
  localparam logic signed [HW-1:0] AMP_P = HW'(AMPLITUDE);
  localparam logic signed [HW-1:0] AMP_N = -AMP_P;
  localparam logic [6:0] N_LAST = 7'(PSS_LEN-1);
  // Bit i holds x(k+i): bit 0 is the current sequence bit, bits 6..0 = 1,1,1,0,1,1,0.
  localparam logic [6:0] LFSR_INIT = 7'b1110110;

  typedef enum logic [1:0] {IDLE, SEEK, EMIT} state_t;

  state_t            state_q, state_d;
  logic [6:0]        lfsr_q, lfsr_d;
  logic [6:0]        shift_q, shift_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [6:0]        n_q, n_d;
  logic              in_rdy_q, in_rdy_d;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [OUT_DW-1:0] dat_q, dat_d;

  logic [6:0]        lfsr_nxt;
  logic              in_hs;
  logic              out_hs;

  // x(k+7) = x(k+4) ^ x(k): shift toward bit 0, new bit enters at bit 6.
  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[4] ^ s[0], s[6:1]};
  endfunction

  function automatic logic [OUT_DW-1:0] bpsk(input logic b);
    return {{(OUT_DW-HW){1'b0}}, (b ? AMP_N : AMP_P)};
  endfunction

  assign lfsr_nxt = lfsr_step(lfsr_q);
  assign in_hs    = in_rdy_q & bus.s_axis_in_tvalid;
  assign out_hs   = vld_q & bus.m_axis_out_tready;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    in_rdy_d = in_rdy_q;
    vld_d    = vld_q;
    last_d   = last_q;
    err_d    = 1'b0;
    dat_d    = dat_q;

    case (state_q)
      IDLE: begin
        in_rdy_d = 1'b1;
        if (in_hs) begin
          if (bus.s_axis_in_tdata == 2'd3) begin
            err_d = 1'b1;
          end else begin
            lfsr_d   = LFSR_INIT;
            cnt_d    = '0;
            n_d      = '0;
            in_rdy_d = 1'b0;
            case (bus.s_axis_in_tdata)
              2'd1:    shift_d = 7'd43;
              2'd2:    shift_d = 7'd86;
              default: shift_d = 7'd0;
            endcase
            if (bus.s_axis_in_tdata == 2'd0) begin
              // No rotation: the first sample is x(0), present straight away.
              state_d = EMIT;
              vld_d   = 1'b1;
              last_d  = 1'b0;
              dat_d   = bpsk(LFSR_INIT[0]);
            end else begin
              state_d = SEEK;
            end
          end
        end
      end

      SEEK: begin
        // Free-running advance of the LFSR by the rotation amount; the output
        // register is loaded on the last step so valid rises with EMIT.
        lfsr_d = lfsr_nxt;
        cnt_d  = cnt_q + 7'd1;
        if (cnt_q == shift_q - 7'd1) begin
          state_d = EMIT;
          vld_d   = 1'b1;
          last_d  = 1'b0;
          dat_d   = bpsk(lfsr_nxt[0]);
        end
      end

      EMIT: begin
        if (out_hs) begin
          if (n_q == N_LAST) begin
            state_d  = IDLE;
            vld_d    = 1'b0;
            last_d   = 1'b0;
            dat_d    = '0;
            in_rdy_d = 1'b1;
          end else begin
            lfsr_d = lfsr_nxt;
            n_d    = n_q + 7'd1;
            dat_d  = bpsk(lfsr_nxt[0]);
            last_d = ((n_q + 7'd1) == N_LAST);
          end
        end
      end

      default: begin
        state_d  = IDLE;
        vld_d    = 1'b0;
        in_rdy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_INIT;
      shift_q  <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      in_rdy_q <= 1'b0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      in_rdy_q <= in_rdy_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
    end
  end

  assign bus.s_axis_in_tready  = in_rdy_q;
  assign bus.m_axis_out_tvalid = vld_q;
  assign bus.m_axis_out_tdata  = dat_q;
  assign bus.m_axis_out_tlast  = last_q;
  assign bus.err_o             = err_q;

endmodule

// File: tb/tb_pss_generator.sv
// Bench for pss_generator: sequence model d(n) = 1 - 2*x((n + 43*k) mod 127) built from
// the recurrence, compared against every valid output beat, plus directed latency,
// backpressure, invalid-request and reset-abort scenarios.
module tb_pss_generator;

  localparam int A = 32767;

  logic clk;
  logic reset_ni;

  pss_generator_if #(.OUT_DW(32)) bus ();

  pss_generator #(.OUT_DW(32)) dut (
    .clk_i    (clk),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit ex [0:126];

  int req_id = 0;
  int req_k  = 0;
  bit bp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_sample(input int k, input int n);
    logic [15:0] re;
    re = ex[(n + 43*k) % 127] ? 16'(-A) : 16'(A);
    return {16'h0000, re};
  endfunction

  // Downstream ready: always high unless backpressure is enabled.
  always @(posedge clk) begin
    #1;
    bus.m_axis_out_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: checks every valid beat against the model.
  int  seen_id    = 0;
  bit  active     = 1'b0;
  int  cur_k      = 0;
  int  beat       = 0;
  bit  stall_prev = 1'b0;
  bit  chk_idle   = 1'b0;
  logic [31:0] prev_dat;
  logic        prev_last;

  always @(negedge clk) begin
    if (!reset_ni) begin
      active     = 1'b0;
      stall_prev = 1'b0;
      chk_idle   = 1'b0;
      seen_id    = req_id;
    end else begin
      if (req_id != seen_id) begin
        seen_id = req_id;
        active  = 1'b1;
        beat    = 0;
        cur_k   = req_k;
      end
      if (chk_idle) begin
        check("ready_after_last", 32'(bus.s_axis_in_tready), 32'd1);
        check("valid_after_last", 32'(bus.m_axis_out_tvalid), 32'd0);
        chk_idle = 1'b0;
      end
      if (bus.m_axis_out_tvalid) begin
        if (!active) begin
          check("unexpected_valid", 32'(bus.m_axis_out_tvalid), 32'd0);
        end else begin
          check("sample", bus.m_axis_out_tdata, exp_sample(cur_k, beat));
          check("tlast", 32'(bus.m_axis_out_tlast), 32'(beat == 126));
          check("in_ready_busy", 32'(bus.s_axis_in_tready), 32'd0);
          if (stall_prev) begin
            check("stall_hold_data", bus.m_axis_out_tdata, prev_dat);
            check("stall_hold_last", 32'(bus.m_axis_out_tlast), 32'(prev_last));
          end
          if (bus.m_axis_out_tready) begin
            beat++;
            if (beat == 127) begin
              active   = 1'b0;
              chk_idle = 1'b1;
            end
          end
        end
        stall_prev = !bus.m_axis_out_tready;
        prev_dat   = bus.m_axis_out_tdata;
        prev_last  = bus.m_axis_out_tlast;
      end else begin
        if (stall_prev) check("valid_dropped_while_stalled", 32'd0, 32'd1);
        stall_prev = 1'b0;
      end
    end
  end

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (!bus.s_axis_in_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(bus.s_axis_in_tready), 32'd1);
  endtask

  // Issue a request; handshake completes on the following rising edge.
  task automatic send_req(input int k, input bit counted);
    @(posedge clk); #1;
    bus.s_axis_in_tdata  = 2'(k);
    bus.s_axis_in_tvalid = 1'b1;
    if (counted) begin
      req_k = k;
      req_id++;
    end
    @(posedge clk); #1;
    bus.s_axis_in_tvalid = 1'b0;
    bus.s_axis_in_tdata  = 2'd0;
  endtask

  task automatic run_req(input int k, input bit bp, input int exp_lat);
    int cyc, vcyc, beats;
    wait_in_ready();
    send_req(k, 1'b1);
    bp_en = bp;
    @(negedge clk);
    cyc = 1;
    check("err_on_valid_req", 32'(bus.err_o), 32'd0);
    check("in_ready_after_req", 32'(bus.s_axis_in_tready), 32'd0);
    while (!bus.m_axis_out_tvalid && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("first_valid_latency", 32'(cyc), 32'(exp_lat));
    vcyc  = 0;
    beats = 0;
    while (bus.m_axis_out_tvalid && vcyc < 2000) begin
      vcyc++;
      if (bus.m_axis_out_tready) beats++;
      @(negedge clk);
    end
    check("beats_transferred", 32'(beats), 32'd127);
    if (!bp) check("valid_cycles", 32'(vcyc), 32'd127);
    bp_en = 1'b0;
  endtask

  initial begin
    int sum;
    int cnt;
    bit pin [0:10];

    reset_ni              = 1'b0;
    bus.s_axis_in_tdata   = 2'd0;
    bus.s_axis_in_tvalid  = 1'b0;
    bus.m_axis_out_tready = 1'b1;

    // Sequence model from the defining recurrence.
    ex[0] = 0; ex[1] = 1; ex[2] = 1; ex[3] = 0; ex[4] = 1; ex[5] = 1; ex[6] = 1;
    for (int i = 0; i < 120; i++) ex[i+7] = ex[i+4] ^ ex[i];

    // Hand-derived first bits: x7 = x4^x0 = 1, x8 = x5^x1 = 0, x9 = x6^x2 = 0, x10 = x7^x3 = 1.
    pin = '{0, 1, 1, 0, 1, 1, 1, 1, 0, 0, 1};
    for (int i = 0; i < 11; i++) check("model_bit", 32'(ex[i]), 32'(pin[i]));
    sum = 0;
    for (int i = 0; i < 127; i++) sum += int'(ex[i]);
    check("model_ones", 32'(sum), 32'd64);
    check("model_n0", exp_sample(0, 0), 32'h0000_7FFF);
    check("model_n1", exp_sample(0, 1), 32'h0000_8001);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.s_axis_in_tready), 32'd0);
    check("rst_valid", 32'(bus.m_axis_out_tvalid), 32'd0);
    check("rst_data", bus.m_axis_out_tdata, 32'd0);
    check("rst_last", 32'(bus.m_axis_out_tlast), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    @(posedge clk); #1;
    reset_ni = 1'b1;
    @(negedge clk);
    check("ready_still_low", 32'(bus.s_axis_in_tready), 32'd0);
    @(negedge clk);
    check("ready_after_release", 32'(bus.s_axis_in_tready), 32'd1);

    // Each N_id_2 with free-flowing output.
    run_req(0, 1'b0, 1);
    run_req(1, 1'b0, 44);
    run_req(2, 1'b0, 87);

    // Random backpressure.
    run_req(0, 1'b1, 1);
    run_req(2, 1'b1, 87);

    // Invalid N_id_2.
    wait_in_ready();
    send_req(3, 1'b0);
    @(negedge clk);
    check("err_pulse", 32'(bus.err_o), 32'd1);
    check("ready_after_invalid", 32'(bus.s_axis_in_tready), 32'd1);
    @(negedge clk);
    check("err_one_cycle", 32'(bus.err_o), 32'd0);
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.m_axis_out_tvalid) cnt++;
    end
    check("no_valid_after_invalid", 32'(cnt), 32'd0);
    run_req(1, 1'b0, 44);

    // Reset in the middle of EMIT at beat n=50.
    wait_in_ready();
    send_req(0, 1'b1);
    cnt = 0;
    while (!bus.m_axis_out_tvalid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_run_started", 32'(bus.m_axis_out_tvalid), 32'd1);
    repeat (49) @(negedge clk);
    @(posedge clk); #1;
    reset_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_valid", 32'(bus.m_axis_out_tvalid), 32'd0);
    check("abort_data", bus.m_axis_out_tdata, 32'd0);
    check("abort_last", 32'(bus.m_axis_out_tlast), 32'd0);
    check("abort_in_ready", 32'(bus.s_axis_in_tready), 32'd0);
    @(posedge clk); #1;
    reset_ni = 1'b1;
    @(negedge clk);
    check("abort_ready_low", 32'(bus.s_axis_in_tready), 32'd0);
    run_req(0, 1'b0, 1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
